// File: rtl/riscv_csr_arbiter_if.sv
// rtl/riscv_csr_arbiter_if.sv - core, debug and CSR-file signals seen by riscv_csr_arbiter
interface riscv_csr_arbiter_if;
    logic        core_csr_access_i;
    logic [11:0] core_csr_addr_i;
    logic [31:0] core_csr_wdata_i;
    logic [1:0]  core_csr_op_i;
    logic [31:0] core_csr_rdata_o;
    logic        core_stall_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [11:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        exc_busy_i;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;

    modport slave (
        input  core_csr_access_i, core_csr_addr_i, core_csr_wdata_i, core_csr_op_i,
        output core_csr_rdata_o, core_stall_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  exc_busy_i,
        output csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
        input  csr_rdata_i
    );

    modport master (
        output core_csr_access_i, core_csr_addr_i, core_csr_wdata_i, core_csr_op_i,
        input  core_csr_rdata_o, core_stall_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output exc_busy_i,
        input  csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
        output csr_rdata_i
    );
endinterface

// File: rtl/riscv_csr_arbiter.sv
// rtl/riscv_csr_arbiter.sv - shares the CSR file port between core and debug unit
// Optional macro CSR_ARB_STARVE_EN builds the debug anti-starvation wait counter.
module riscv_csr_arbiter #(
    parameter int DBG_WAIT_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_csr_arbiter_if.slave   bus
);
    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;

    if (DBG_WAIT_MAX < 1 || DBG_WAIT_MAX > 255) begin : g_param_check
        $error("DBG_WAIT_MAX must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DBG_ACC  = 2'd1,
        DBG_RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic        gnt_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        starve;
    logic        eligible;
    logic        in_acc;

    assign in_acc   = (state_q == DBG_ACC);
    assign eligible = bus.dbg_req_i & ~bus.exc_busy_i & (~bus.core_csr_access_i | starve);

`ifdef CSR_ARB_STARVE_EN
    localparam logic [7:0] WAIT_MAX_C = 8'(DBG_WAIT_MAX);

    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    // Counts cycles the core pushed a ready debug request aside; saturates at the limit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (in_acc || !bus.dbg_req_i) begin
            wait_cnt_d = '0;
        end else if (!bus.exc_busy_i && bus.core_csr_access_i && !starve) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign starve = (wait_cnt_q == WAIT_MAX_C);
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 1'b0;
                    if (eligible) begin
                        state_q <= DBG_ACC;
                        gnt_q   <= 1'b1;
                    end
                end
                DBG_ACC: begin
                    // Read data is sampled before the write lands, so writes return the old value.
                    state_q  <= DBG_RESP;
                    gnt_q    <= 1'b0;
                    rvalid_q <= 1'b1;
                    rdata_q  <= bus.csr_rdata_i;
                end
                DBG_RESP: begin
                    rvalid_q <= 1'b0;
                    if (eligible) begin
                        state_q <= DBG_ACC;
                        gnt_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    gnt_q    <= 1'b0;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dbg_gnt_o        = gnt_q;
    assign bus.dbg_rvalid_o     = rvalid_q;
    assign bus.dbg_rdata_o      = rdata_q;
    assign bus.core_stall_o     = in_acc & bus.core_csr_access_i;
    assign bus.core_csr_rdata_o = bus.csr_rdata_i;

    assign bus.csr_access_o = in_acc | bus.core_csr_access_i;
    assign bus.csr_addr_o   = in_acc ? bus.dbg_addr_i  : bus.core_csr_addr_i;
    assign bus.csr_wdata_o  = in_acc ? bus.dbg_wdata_i : bus.core_csr_wdata_i;
    assign bus.csr_op_o     = in_acc ? (bus.dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE)
                                     : (bus.core_csr_access_i ? bus.core_csr_op_i : CSR_OP_NONE);
endmodule

// File: tb/tb_riscv_csr_arbiter.sv
// tb/tb_riscv_csr_arbiter.sv - self-checking bench for riscv_csr_arbiter
module tb_riscv_csr_arbiter;
    localparam int WMAX = 4;
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    riscv_csr_arbiter_if bus ();

    riscv_csr_arbiter #(.DBG_WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // CSR register file seen by the DUT
    logic [31:0] csr_file [0:4095];
    assign bus.csr_rdata_i = csr_file[bus.csr_addr_o];
    always @(posedge clk) begin
        if (bus.csr_access_o) begin
            case (bus.csr_op_o)
                OP_WRITE: csr_file[bus.csr_addr_o] <= bus.csr_wdata_o;
                OP_SET:   csr_file[bus.csr_addr_o] <= csr_file[bus.csr_addr_o] | bus.csr_wdata_o;
                OP_CLEAR: csr_file[bus.csr_addr_o] <= csr_file[bus.csr_addr_o] & ~bus.csr_wdata_o;
                default:  ;
            endcase
        end
    end

    // Reference model: a grant follows any eligible cycle that was not itself a grant
    logic [31:0] ref_mem [0:4095];
    logic        m_gnt_prev;
    logic        m_elig_prev;
    int          m_cnt;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt_prev  = 1'b0;
        m_elig_prev = 1'b0;
        m_cnt       = 0;
        m_rdata     = '0;
    endtask

    task automatic model_cycle();
        logic        e_gnt, e_rv, e_stall, e_acc, elig, starve;
        logic [11:0] e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_op;
        e_gnt   = m_elig_prev & ~m_gnt_prev;
        e_rv    = m_gnt_prev;
        e_stall = e_gnt & bus.core_csr_access_i;
        if (e_gnt) begin
            e_acc  = 1'b1;
            e_addr = bus.dbg_addr_i;
            e_wd   = bus.dbg_wdata_i;
            e_op   = bus.dbg_we_i ? OP_WRITE : OP_NONE;
        end else begin
            e_acc  = bus.core_csr_access_i;
            e_addr = bus.core_csr_addr_i;
            e_wd   = bus.core_csr_wdata_i;
            e_op   = bus.core_csr_access_i ? bus.core_csr_op_i : OP_NONE;
        end
        chk("m_gnt",        32'(bus.dbg_gnt_o),    32'(e_gnt));
        chk("m_rvalid",     32'(bus.dbg_rvalid_o), 32'(e_rv));
        chk("m_stall",      32'(bus.core_stall_o), 32'(e_stall));
        chk("m_csr_access", 32'(bus.csr_access_o), 32'(e_acc));
        chk("m_csr_op",     32'(bus.csr_op_o),     32'(e_op));
        chk("m_csr_addr",   32'(bus.csr_addr_o),   32'(e_addr));
        chk("m_csr_wdata",  bus.csr_wdata_o,       e_wd);
        chk("m_dbg_rdata",  bus.dbg_rdata_o,       m_rdata);
        chk("m_core_rdata", bus.core_csr_rdata_o,  ref_mem[e_addr]);
`ifdef CSR_ARB_STARVE_EN
        starve = (m_cnt == WMAX);
`else
        starve = 1'b0;
`endif
        elig = bus.dbg_req_i & ~bus.exc_busy_i & (~bus.core_csr_access_i | starve);
        if (e_gnt) m_rdata = ref_mem[bus.dbg_addr_i];
        if (e_acc) begin
            case (e_op)
                OP_WRITE: ref_mem[e_addr] = e_wd;
                OP_SET:   ref_mem[e_addr] = ref_mem[e_addr] | e_wd;
                OP_CLEAR: ref_mem[e_addr] = ref_mem[e_addr] & ~e_wd;
                default:  ;
            endcase
        end
        if (e_gnt || !bus.dbg_req_i) m_cnt = 0;
        else if (!bus.exc_busy_i && bus.core_csr_access_i && !starve && m_cnt < WMAX) m_cnt++;
        m_elig_prev = elig;
        m_gnt_prev  = e_gnt;
    endtask

    task automatic set_inputs(input logic ca, input logic [11:0] caddr, input logic [31:0] cwd,
                              input logic [1:0] cop, input logic dr, input logic dwe,
                              input logic [11:0] daddr, input logic [31:0] dwd, input logic exc);
        bus.core_csr_access_i = ca;
        bus.core_csr_addr_i   = caddr;
        bus.core_csr_wdata_i  = cwd;
        bus.core_csr_op_i     = cop;
        bus.dbg_req_i         = dr;
        bus.dbg_we_i          = dwe;
        bus.dbg_addr_i        = daddr;
        bus.dbg_wdata_i       = dwd;
        bus.exc_busy_i        = exc;
    endtask

    task automatic drive(input logic ca, input logic [11:0] caddr, input logic [31:0] cwd,
                         input logic [1:0] cop, input logic dr, input logic dwe,
                         input logic [11:0] daddr, input logic [31:0] dwd, input logic exc);
        @(negedge clk);
        set_inputs(ca, caddr, cwd, cop, dr, dwe, daddr, dwd, exc);
        #1;
        model_cycle();
    endtask

    task automatic idle();
        drive(1'b0, 12'h0, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    endtask

    typedef struct {
        logic        ca;
        logic [11:0] caddr;
        logic [31:0] cwd;
        logic [1:0]  cop;
        logic        dr;
        logic        dwe;
        logic [11:0] daddr;
        logic [31:0] dwd;
        logic        exc;
        logic        e_gnt;
        logic        e_rv;
        logic        e_stall;
        logic [1:0]  e_op;
        logic [11:0] e_addr;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int          first_gnt;
        int          stall_cnt;
        int          stall_cyc;
        int          rv_cyc;
        logic        g_req, g_we;
        logic [11:0] g_addr;
        logic [31:0] g_wd;

        tbl[0]  = '{1'b1, 12'h341, 32'h1000, OP_WRITE, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, OP_WRITE, 12'h341, 32'h0};
        tbl[1]  = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b0, 12'h300, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, OP_NONE, 12'h000, 32'h0};
        tbl[2]  = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b0, 12'h300, 32'h0, 1'b0,
                    1'b1, 1'b0, 1'b0, OP_NONE, 12'h300, 32'h0};
        tbl[3]  = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, OP_NONE, 12'h000, 32'h7};
        for (int i = 4; i < 8; i++)
            tbl[i] = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b1, 12'h341, 32'hCAFE0001, 1'b1,
                       1'b0, 1'b0, 1'b0, OP_NONE, 12'h000, 32'h0};
        tbl[8]  = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b1, 12'h341, 32'hCAFE0001, 1'b0,
                    1'b0, 1'b0, 1'b0, OP_NONE, 12'h000, 32'h0};
        tbl[9]  = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b1, 12'h341, 32'hCAFE0001, 1'b0,
                    1'b1, 1'b0, 1'b0, OP_WRITE, 12'h341, 32'h0};
        tbl[10] = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, OP_NONE, 12'h000, 32'h1000};
        tbl[11] = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, OP_NONE, 12'h000, 32'h0};
        tbl[12] = '{1'b0, 12'h000, 32'h0, OP_NONE, 1'b1, 1'b0, 12'h341, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, OP_NONE, 12'h000, 32'h0};
        tbl[13] = '{1'b1, 12'h305, 32'h10, OP_SET, 1'b1, 1'b0, 12'h341, 32'h0, 1'b0,
                    1'b1, 1'b0, 1'b1, OP_NONE, 12'h341, 32'h0};
        tbl[14] = '{1'b1, 12'h305, 32'h10, OP_SET, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0,
                    1'b0, 1'b1, 1'b0, OP_SET, 12'h305, 32'hCAFE0001};

        for (int i = 0; i < 4096; i++) begin
            csr_file[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        csr_file[12'h300] = 32'h7;
        ref_mem[12'h300]  = 32'h7;

        set_inputs(1'b0, 12'h0, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt",    32'(bus.dbg_gnt_o),    32'h0);
        chk("rst_rvalid", 32'(bus.dbg_rvalid_o), 32'h0);
        chk("rst_rdata",  bus.dbg_rdata_o,       32'h0);
        chk("rst_stall",  32'(bus.core_stall_o), 32'h0);
        chk("rst_op",     32'(bus.csr_op_o),     32'(OP_NONE));
        chk("rst_access", 32'(bus.csr_access_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].ca, tbl[i].caddr, tbl[i].cwd, tbl[i].cop, tbl[i].dr, tbl[i].dwe,
                  tbl[i].daddr, tbl[i].dwd, tbl[i].exc);
            chk($sformatf("tbl%0d_gnt", i),   32'(bus.dbg_gnt_o),    32'(tbl[i].e_gnt));
            chk($sformatf("tbl%0d_rv", i),    32'(bus.dbg_rvalid_o), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_stall", i), 32'(bus.core_stall_o), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_op", i),    32'(bus.csr_op_o),     32'(tbl[i].e_op));
            chk($sformatf("tbl%0d_addr", i),  32'(bus.csr_addr_o),   32'(tbl[i].e_addr));
            if (tbl[i].e_rv)
                chk($sformatf("tbl%0d_rdata", i), bus.dbg_rdata_o, tbl[i].e_rdata);
        end

        // Debug read while the core keeps the port busy
        idle();
        idle();
        first_gnt = -1;
        stall_cnt = 0;
        stall_cyc = -1;
        rv_cyc    = -1;
        for (int c = 0; c < 16; c++) begin
`ifdef CSR_ARB_STARVE_EN
            drive(1'b1, 12'h305, 32'h0, OP_NONE, first_gnt < 0, 1'b0, 12'h300, 32'h0, 1'b0);
`else
            drive(c <= 5, 12'h305, 32'h0, OP_NONE, first_gnt < 0, 1'b0, 12'h300, 32'h0, 1'b0);
`endif
            if (bus.dbg_gnt_o && first_gnt < 0) first_gnt = c;
            if (bus.dbg_rvalid_o && rv_cyc < 0) rv_cyc = c;
            if (bus.core_stall_o) begin
                stall_cnt++;
                stall_cyc = c;
            end
        end
`ifdef CSR_ARB_STARVE_EN
        chk("starve_gnt_cycle",   32'(first_gnt), 32'd5);
        chk("starve_stall_count", 32'(stall_cnt), 32'd1);
        chk("starve_stall_cycle", 32'(stall_cyc), 32'd5);
        chk("starve_rv_cycle",    32'(rv_cyc),    32'd6);
`else
        chk("coll_gnt_cycle",   32'(first_gnt), 32'd7);
        chk("coll_stall_count", 32'(stall_cnt), 32'd0);
        chk("coll_rv_cycle",    32'(rv_cyc),    32'd8);
`endif
        chk("coll_rdata", bus.dbg_rdata_o, 32'h7);

        // Reset while a grant is outstanding drops the response
        idle();
        idle();
        drive(1'b0, 12'h0, 32'h0, OP_NONE, 1'b1, 1'b0, 12'h341, 32'h0, 1'b0);
        drive(1'b0, 12'h0, 32'h0, OP_NONE, 1'b1, 1'b0, 12'h341, 32'h0, 1'b0);
        chk("rstmid_gnt_before", 32'(bus.dbg_gnt_o), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid_gnt_async", 32'(bus.dbg_gnt_o), 32'h0);
        model_reset();
        set_inputs(1'b0, 12'h0, 32'h0, OP_NONE, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        chk("rstmid_rvalid", 32'(bus.dbg_rvalid_o), 32'h0);
        chk("rstmid_rdata",  bus.dbg_rdata_o,       32'h0);
        idle();
        chk("rstmid_idle_gnt", 32'(bus.dbg_gnt_o), 32'h0);

        // Random traffic against the reference model
        g_req  = 1'b0;
        g_we   = 1'b0;
        g_addr = 12'h300;
        g_wd   = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!g_req || m_gnt_prev) begin
                g_req  = 1'($urandom % 2);
                g_we   = 1'($urandom % 2);
                g_addr = 12'h300 + 12'($urandom_range(0, 3));
                g_wd   = $urandom;
            end
            drive(1'($urandom % 2), 12'h300 + 12'($urandom_range(0, 3)), $urandom,
                  2'($urandom), g_req, g_we, g_addr, g_wd, ($urandom % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_csr_arbiter.md
# riscv_csr_arbiter

Shares the single port of the core CSR register file between the ID-stage CSR instruction path and the debug unit. Core accesses pass through combinationally. Debug accesses are granted in dedicated cycles through a small FSM with a req/gnt/rvalid handshake. The block sits between the ID stage, the debug unit and the CSR register file, and holds debug off while an exception save/restore is in flight.

## Interface
Parameters:
- DBG_WAIT_MAX, default 8: maximum number of cycles a pending debug request may be blocked by core accesses. Only used when CSR_ARB_STARVE_EN is defined; range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- core_csr_access_i  in  1  ID stage performs a CSR instruction
- core_csr_addr_i  in  12  core CSR address
- core_csr_wdata_i  in  32  core write data
- core_csr_op_i  in  2  core op (CSR_OP_NONE/WRITE/SET/CLEAR)
- core_csr_rdata_o  out  32  read data to core
- core_stall_o  out  1  core CSR access blocked this cycle; ID must hold
- dbg_req_i  in  1  debug access request; held with addr/wdata/we until gnt
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_addr_i  in  12  debug CSR address
- dbg_wdata_i  in  32  debug write data
- dbg_gnt_o  out  1  debug access executes this cycle
- dbg_rvalid_o  out  1  dbg_rdata_o valid (one-cycle pulse)
- dbg_rdata_o  out  32  registered debug read data
- exc_busy_i  in  1  exception save/restore or cause update in progress
- csr_access_o  out  1  to CSR file
- csr_addr_o  out  12  to CSR file
- csr_wdata_o  out  32  to CSR file
- csr_op_o  out  2  to CSR file
- csr_rdata_i  in  32  combinational read data from CSR file

## Operation
- FSM states: IDLE, DBG_ACC, DBG_RESP.
- Eligible = dbg_req_i & ~exc_busy_i & (~core_csr_access_i | starve). Without the macro, starve = 0.
- IDLE: if eligible -> DBG_ACC, else stay.
- DBG_ACC: dbg_gnt_o=1. CSR port is driven by debug: csr_access_o=1, csr_addr_o=dbg_addr_i, csr_wdata_o=dbg_wdata_i, csr_op_o = dbg_we_i ? CSR_OP_WRITE : CSR_OP_NONE. csr_rdata_i is captured into dbg_rdata_o (pre-write value on a write). core_stall_o = core_csr_access_i. Next state is always DBG_RESP.
- DBG_RESP: dbg_rvalid_o=1. Core pass-through is active. If eligible -> DBG_ACC, else -> IDLE.
- Pass-through (IDLE, DBG_RESP): csr_access_o/addr/wdata follow the core inputs. csr_op_o = core_csr_access_i ? core_csr_op_i : CSR_OP_NONE, so no stray write occurs when the core is idle.
- core_csr_rdata_o = csr_rdata_i at all times. It is meaningful only when core_stall_o=0.
- exc_busy_i never affects the core path. It only blocks entry to DBG_ACC. If it rises during DBG_ACC, the access completes.

## Timing
- Debug latency: eligible in cycle N -> dbg_gnt_o in N+1 -> dbg_rvalid_o and data in N+2.
- Peak debug throughput: one access per 2 cycles, via DBG_RESP -> DBG_ACC.
- Core path has zero added latency, except for a 1-cycle stall when it collides with DBG_ACC.
- The debug side must not change addr/wdata/we between req and gnt. dbg_req_i may drop in the cycle after gnt.
- Reset values: state IDLE, dbg_gnt_o=0, dbg_rvalid_o=0, dbg_rdata_o=0, core_stall_o=0, wait counter=0, csr_op_o=CSR_OP_NONE, csr_access_o=0.
- Reset asserted mid-operation aborts the FSM. No rvalid is issued for an access that was granted but not yet answered.

## Configuration
- CSR_ARB_STARVE_EN defined: an 8-bit wait counter is built.
  - It increments each cycle dbg_req_i=1, exc_busy_i=0 and the core blocks the request. It saturates at DBG_WAIT_MAX.
  - It clears on DBG_ACC or when dbg_req_i=0.
  - starve = (count == DBG_WAIT_MAX). The debug access is then granted even while the core is accessing, and the core is stalled.
- Not defined: no counter. Debug is granted only in cycles with core_csr_access_i=0, so debug can be starved indefinitely.

## Test plan
- Core only: core write 0x341 data 0x0000_1000 op WRITE -> same cycle csr_op_o=WRITE, csr_addr_o=0x341, core_stall_o=0, no dbg_gnt_o.
- Debug read idle: mstatus=0x7, dbg_req read 0x300 at cycle 0 -> dbg_gnt_o cycle 1, csr_op_o=NONE, dbg_rvalid_o cycle 2, dbg_rdata_o=0x0000_0007.
- Collision, macro off: core_csr_access_i=1 for cycles 0-5, dbg_req from cycle 0 -> no gnt until cycle 7, core_stall_o never set.
- Starvation, macro on, DBG_WAIT_MAX=4: continuous core access, dbg_req from cycle 0 -> gnt cycle 5, core_stall_o=1 in cycle 5 only, rvalid cycle 6.
- exc_busy_i=1 cycles 0-3 with dbg_req -> gnt cycle 5. Debug write to 0x341 then lands with csr_op_o=WRITE.
- rst pulse during DBG_ACC -> next cycle dbg_rvalid_o=0, dbg_rdata_o=0, state IDLE.
